// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multi-cycle RV32I datapath and its main FSM.
// ILLEGAL_INSTR_EN adds the o_illegal_instr trap flag.
interface multicycle_control_fsm_if;
    logic [6:0] i_op;
    logic       i_mem_ready;
    logic [1:0] o_alu_op;
    logic [1:0] o_alu_src_a;
    logic [1:0] o_alu_src_b;
    logic [1:0] o_result_src;
    logic       o_adr_src;
    logic       o_pc_write;
    logic       o_branch;
    logic       o_ir_write;
    logic       o_reg_write;
    logic       o_mem_write;
    logic       o_mem_req;
    logic [3:0] o_state;
`ifdef ILLEGAL_INSTR_EN
    logic       o_illegal_instr;
`endif

    modport master (
`ifdef ILLEGAL_INSTR_EN
        input  o_illegal_instr,
`endif
        output i_op, i_mem_ready,
        input  o_alu_op, o_alu_src_a, o_alu_src_b, o_result_src, o_adr_src,
               o_pc_write, o_branch, o_ir_write, o_reg_write, o_mem_write,
               o_mem_req, o_state
    );

    modport slave (
`ifdef ILLEGAL_INSTR_EN
        output o_illegal_instr,
`endif
        input  i_op, i_mem_ready,
        output o_alu_op, o_alu_src_a, o_alu_src_b, o_result_src, o_adr_src,
               o_pc_write, o_branch, o_ir_write, o_reg_write, o_mem_write,
               o_mem_req, o_state
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multi-cycle RV32I core (fetch/decode/execute/writeback).
// ILLEGAL_INSTR_EN: unknown opcodes trap in TRAP instead of retiring as a NOP.
module multicycle_control_fsm #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic                    i_clk,
    input  logic                    i_arst,
    multicycle_control_fsm_if.slave bus
);
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXEC_R    = 4'd6,
        EXEC_I    = 4'd7,
        ALU_WB    = 4'd8,
        BRANCH    = 4'd9,
        JAL       = 4'd10,
        JALR_ADDR = 4'd11,
        LUI       = 4'd12,
        AUIPC     = 4'd13,
        TRAP      = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_t     state, state_nxt;
    logic [1:0] alu_op, src_a, src_b, result_src;
    logic       adr_src, pc_write, branch, ir_write, reg_write, mem_write, mem_req;
    logic       illegal;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) state <= state_t'(RESET_STATE);
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        alu_op     = 2'b00;
        src_a      = 2'b00;
        src_b      = 2'b00;
        result_src = 2'b00;
        adr_src    = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        mem_req    = 1'b0;
        illegal    = 1'b0;
        case (state)
            FETCH: begin
                mem_req    = 1'b1;
                src_b      = 2'b10;
                result_src = 2'b10;
                ir_write   = bus.i_mem_ready;
                pc_write   = bus.i_mem_ready;
                if (bus.i_mem_ready) state_nxt = DECODE;
            end
            DECODE: begin
                // ALU-out captures PC+imm here for branch/JAL targets
                src_a = 2'b01;
                src_b = 2'b01;
                case (bus.i_op)
                    OP_LOAD, OP_STORE: state_nxt = MEM_ADDR;
                    OP_R:              state_nxt = EXEC_R;
                    OP_I:              state_nxt = EXEC_I;
                    OP_BRANCH:         state_nxt = BRANCH;
                    OP_JAL:            state_nxt = JAL;
                    OP_JALR:           state_nxt = JALR_ADDR;
                    OP_LUI:            state_nxt = LUI;
                    OP_AUIPC:          state_nxt = AUIPC;
`ifdef ILLEGAL_INSTR_EN
                    default:           state_nxt = TRAP;
`else
                    default:           state_nxt = FETCH;
`endif
                endcase
            end
            MEM_ADDR: begin
                src_a     = 2'b10;
                src_b     = 2'b01;
                state_nxt = bus.i_op[5] ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                adr_src = 1'b1;
                mem_req = 1'b1;
                if (bus.i_mem_ready) state_nxt = MEM_WB;
            end
            MEM_WB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_nxt  = FETCH;
            end
            MEM_WRITE: begin
                adr_src   = 1'b1;
                mem_req   = 1'b1;
                mem_write = 1'b1;
                if (bus.i_mem_ready) state_nxt = FETCH;
            end
            EXEC_R: begin
                src_a     = 2'b10;
                alu_op    = 2'b10;
                state_nxt = ALU_WB;
            end
            EXEC_I: begin
                src_a     = 2'b10;
                src_b     = 2'b01;
                alu_op    = 2'b10;
                state_nxt = ALU_WB;
            end
            ALU_WB: begin
                reg_write = 1'b1;
                state_nxt = FETCH;
            end
            BRANCH: begin
                src_a     = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
                state_nxt = FETCH;
            end
            JAL: begin
                // PC takes the target from ALU-out while the ALU forms old PC + 4 for rd
                src_a     = 2'b01;
                src_b     = 2'b10;
                pc_write  = 1'b1;
                state_nxt = ALU_WB;
            end
            JALR_ADDR: begin
                src_a     = 2'b10;
                src_b     = 2'b01;
                state_nxt = JAL;
            end
            LUI: begin
                src_a     = 2'b11;
                src_b     = 2'b01;
                state_nxt = ALU_WB;
            end
            AUIPC: begin
                src_a     = 2'b01;
                src_b     = 2'b01;
                state_nxt = ALU_WB;
            end
            TRAP: begin
                illegal   = 1'b1;
                state_nxt = TRAP;
            end
            default: state_nxt = FETCH;
        endcase
        // State is already FETCH during reset; keep it from launching a fetch early
        if (i_arst) begin
            pc_write  = 1'b0;
            branch    = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            mem_write = 1'b0;
            mem_req   = 1'b0;
            illegal   = 1'b0;
        end
    end

    assign bus.o_alu_op     = alu_op;
    assign bus.o_alu_src_a  = src_a;
    assign bus.o_alu_src_b  = src_b;
    assign bus.o_result_src = result_src;
    assign bus.o_adr_src    = adr_src;
    assign bus.o_pc_write   = pc_write;
    assign bus.o_branch     = branch;
    assign bus.o_ir_write   = ir_write;
    assign bus.o_reg_write  = reg_write;
    assign bus.o_mem_write  = mem_write;
    assign bus.o_mem_req    = mem_req;
    assign bus.o_state      = state;
`ifdef ILLEGAL_INSTR_EN
    assign bus.o_illegal_instr = illegal;
`else
    logic unused_illegal;
    assign unused_illegal = illegal;
`endif
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized self-checking bench: an instruction-level model expands each opcode
// into its expected per-cycle control trace and compares it against the FSM.
module tb_multicycle_control_fsm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nchk = 0;
    int   nerr = 0;

    multicycle_control_fsm_if bus();

    multicycle_control_fsm #(.RESET_STATE(4'd0)) dut (
        .i_clk (clk),
        .i_arst(rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic [1:0] alu_op, src_a, src_b, res;
        logic       adr, pcw, br, irw, rw, mw, mreq, ill;
    } ctl_t;

    // Control word each state must present, straight from the state descriptions
    function automatic ctl_t ctl(input int st, input bit rdy);
        ctl_t c = '0;
        c.st = 4'(st);
        case (st)
            0:  begin c.mreq = 1; c.src_b = 2; c.res = 2; c.irw = rdy; c.pcw = rdy; end
            1:  begin c.src_a = 1; c.src_b = 1; end
            2:  begin c.src_a = 2; c.src_b = 1; end
            3:  begin c.adr = 1; c.mreq = 1; end
            4:  begin c.res = 1; c.rw = 1; end
            5:  begin c.adr = 1; c.mreq = 1; c.mw = 1; end
            6:  begin c.src_a = 2; c.alu_op = 2; end
            7:  begin c.src_a = 2; c.src_b = 1; c.alu_op = 2; end
            8:  begin c.rw = 1; end
            9:  begin c.src_a = 2; c.alu_op = 1; c.br = 1; end
            10: begin c.src_a = 1; c.src_b = 2; c.pcw = 1; end
            11: begin c.src_a = 2; c.src_b = 1; end
            12: begin c.src_a = 3; c.src_b = 1; end
            13: begin c.src_a = 1; c.src_b = 1; end
            14: begin c.ill = 1; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic ctl_t observed();
        ctl_t c;
        c.st     = bus.o_state;
        c.alu_op = bus.o_alu_op;
        c.src_a  = bus.o_alu_src_a;
        c.src_b  = bus.o_alu_src_b;
        c.res    = bus.o_result_src;
        c.adr    = bus.o_adr_src;
        c.pcw    = bus.o_pc_write;
        c.br     = bus.o_branch;
        c.irw    = bus.o_ir_write;
        c.rw     = bus.o_reg_write;
        c.mw     = bus.o_mem_write;
        c.mreq   = bus.o_mem_req;
`ifdef ILLEGAL_INSTR_EN
        c.ill    = bus.o_illegal_instr;
`else
        c.ill    = 1'b0;
`endif
        return c;
    endfunction

    // One cycle: apply inputs, compare the settled controls, then clock
    task automatic step(input ctl_t exp, input bit rdy, input logic [6:0] op, input string nm);
        ctl_t got;
        bus.i_op = op;
        bus.i_mem_ready = rdy;
        #1;
        got = observed();
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s op=%b st=%0d: got ctl=%h, expected ctl=%h", nm, op, exp.st, got, exp);
        end
        @(posedge clk);
        #1;
    endtask

    // Expand one instruction into its cycle trace; ready is random wherever it must not matter
    task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input string nm);
        int  sts[$];
        bit  rdys[$];
        bit  r;
        repeat (fw) begin sts.push_back(0); rdys.push_back(0); end
        sts.push_back(0); rdys.push_back(1);
        sts.push_back(1); rdys.push_back(1'($urandom_range(0, 1)));
        case (op)
            7'b0000011, 7'b0100011: begin
                sts.push_back(2); rdys.push_back(1'($urandom_range(0, 1)));
                repeat (mw) begin sts.push_back(op[5] ? 5 : 3); rdys.push_back(0); end
                sts.push_back(op[5] ? 5 : 3); rdys.push_back(1);
                if (!op[5]) begin sts.push_back(4); rdys.push_back(1'($urandom_range(0, 1))); end
            end
            7'b0110011: sts = {sts, 6, 8};
            7'b0010011: sts = {sts, 7, 8};
            7'b1100011: sts = {sts, 9};
            7'b1101111: sts = {sts, 10, 8};
            7'b1100111: sts = {sts, 11, 10, 8};
            7'b0110111: sts = {sts, 12, 8};
            7'b0010111: sts = {sts, 13, 8};
            default: ;
        endcase
        for (int i = 0; i < sts.size(); i++) begin
            r = (i < rdys.size()) ? rdys[i] : 1'($urandom_range(0, 1));
            step(ctl(sts[i], r), r, op, nm);
        end
    endtask

    task automatic test_reset();
        ctl_t got;
        bus.i_op = 7'b0110011;
        bus.i_mem_ready = 1'b1;
        rst = 1'b1;
        #1;
        got = observed();
        nchk++;
        if (got.st !== 4'd0 || got.pcw || got.irw || got.rw || got.mw || got.mreq || got.br) begin
            nerr++;
            $display("FAIL reset_hold: got ctl=%h, expected state 0 with no strobes", got);
        end
        bus.i_mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        got = observed();
        nchk++;
        if (got !== ctl(0, 0)) begin
            nerr++;
            $display("FAIL reset_release: got ctl=%h, expected ctl=%h", got, ctl(0, 0));
        end
    endtask

    task automatic test_reset_mid_read();
        ctl_t got;
        step(ctl(0, 1), 1, 7'b0000011, "rst_mid_fetch");
        step(ctl(1, 0), 0, 7'b0000011, "rst_mid_decode");
        step(ctl(2, 0), 0, 7'b0000011, "rst_mid_addr");
        step(ctl(3, 0), 0, 7'b0000011, "rst_mid_read");
        rst = 1'b1;
        #1;
        got = observed();
        nchk++;
        if (got.st !== 4'd0 || got.pcw || got.irw || got.rw || got.mw || got.mreq || got.br) begin
            nerr++;
            $display("FAIL rst_mid_abort: got ctl=%h, expected state 0 with no strobes", got);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        got = observed();
        nchk++;
        if (got !== ctl(0, 0)) begin
            nerr++;
            $display("FAIL rst_mid_release: got ctl=%h, expected ctl=%h", got, ctl(0, 0));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        run_instr(7'b0110011, 0, 0, "r_type");
        run_instr(7'b0000011, 0, 3, "load_wait");
        run_instr(7'b0100011, 2, 2, "store_wait");
        run_instr(7'b1100111, 0, 0, "jalr");
        run_instr(7'b1100011, 0, 0, "branch");
    endtask

    task automatic test_random();
        logic [6:0] legal [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                                  7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        logic [6:0] bad [3] = '{7'b1111111, 7'b0000000, 7'b0001111};
        logic [6:0] op;
        for (int n = 0; n < 300; n++) begin
`ifdef ILLEGAL_INSTR_EN
            op = legal[$urandom_range(0, 8)];
`else
            op = ($urandom_range(0, 9) == 0) ? bad[$urandom_range(0, 2)] : legal[$urandom_range(0, 8)];
`endif
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 4), "random");
        end
    endtask

    task automatic test_illegal();
`ifdef ILLEGAL_INSTR_EN
        step(ctl(0, 1), 1, 7'b1111111, "illegal_fetch");
        step(ctl(1, 1), 1, 7'b1111111, "illegal_decode");
        for (int i = 0; i < 10; i++) begin
            bit r = 1'($urandom_range(0, 1));
            step(ctl(14, r), r, 7'($urandom), "illegal_trap");
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        run_instr(7'b0110011, 0, 0, "after_trap");
`else
        run_instr(7'b1111111, 0, 0, "illegal_nop");
        run_instr(7'b0010011, 0, 0, "after_nop");
`endif
    endtask

    initial begin
        bus.i_op = '0;
        bus.i_mem_ready = 1'b0;
        test_reset();
        test_directed();
        test_reset_mid_read();
        test_random();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main control state machine for the multi-cycle RV32I core.
- Sequences the shared ALU, register file, instruction register and unified memory port across fetch, decode, execute and writeback cycles.
- Drives the 2-bit ALU-op class consumed by the ALU decoder: 00 ADD, 01 SUB/branch, 10 funct-decoded.
- Holds in memory states until the memory port signals ready.

Parameters:
- RESET_STATE, 4'd0 (FETCH), state entered on reset.

Ports:
- i_clk  in  1  clock
- i_arst  in  1  asynchronous active-high reset
- i_op  in  7  opcode field from instruction register
- i_mem_ready  in  1  memory port completed current access this cycle
- o_alu_op  out  2  00 add, 01 sub/compare, 10 funct-decoded
- o_alu_src_a  out  2  00 PC, 01 old PC, 10 rs1, 11 zero
- o_alu_src_b  out  2  00 rs2, 01 immediate, 10 constant 4
- o_result_src  out  2  00 ALU-out register, 01 read data, 10 ALU result
- o_adr_src  out  1  0 PC, 1 result bus
- o_pc_write  out  1  unconditional PC update strobe
- o_branch  out  1  conditional PC update; core ANDs with branch condition
- o_ir_write  out  1  instruction register load strobe
- o_reg_write  out  1  register file write strobe
- o_mem_write  out  1  memory write request
- o_mem_req  out  1  memory access request (fetch, load, store)
- o_state  out  4  current state, for debug

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-high on i_arst, forcing state FETCH.
- Decode: unless listed, all strobes are 0 and muxes are 00. Outputs are Moore, except where qualified by i_mem_ready.
- State encodings:
  - 0 FETCH, 1 DECODE, 2 MEM_ADDR, 3 MEM_READ, 4 MEM_WB, 5 MEM_WRITE, 6 EXEC_R, 7 EXEC_I
  - 8 ALU_WB, 9 BRANCH, 10 JAL, 11 JALR_ADDR, 12 LUI, 13 AUIPC, 14 TRAP
- FETCH:
  - adr_src 0, mem_req 1, src_a 00, src_b 10, alu_op 00, result_src 10.
  - ir_write and pc_write = i_mem_ready.
  - Stay while !i_mem_ready; else go to DECODE.
- DECODE: src_a 01, src_b 01, alu_op 00, so ALU-out holds PC+imm. Next state by i_op:
  - 0000011 or 0100011 -> MEM_ADDR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR_ADDR
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - other -> FETCH, or TRAP with the feature enabled
- MEM_ADDR: src_a 10, src_b 01, alu_op 00. Next is MEM_READ if i_op[5]=0, else MEM_WRITE.
- MEM_READ: result_src 00, adr_src 1, mem_req 1. Hold until i_mem_ready, then MEM_WB.
- MEM_WB: result_src 01, reg_write 1, then FETCH.
- MEM_WRITE: result_src 00, adr_src 1, mem_req 1, mem_write 1. Hold until i_mem_ready, then FETCH.
- EXEC_R: src_a 10, src_b 00, alu_op 10, then ALU_WB.
- EXEC_I: src_a 10, src_b 01, alu_op 10, then ALU_WB.
- ALU_WB: result_src 00, reg_write 1, then FETCH.
- BRANCH: src_a 10, src_b 00, alu_op 01, result_src 00, branch 1, then FETCH.
- JAL: src_a 01, src_b 10, alu_op 00, result_src 00, pc_write 1, then ALU_WB (rd = old PC + 4).
- JALR_ADDR: src_a 10, src_b 01, alu_op 00, then JAL.
- LUI: src_a 11, src_b 01, alu_op 00, then ALU_WB.
- AUIPC: src_a 01, src_b 01, alu_op 00, then ALU_WB.
- Boundary rules:
  - i_mem_ready is ignored outside FETCH, MEM_READ and MEM_WRITE.
  - Reset asserted mid-instruction aborts it; no strobe fires in the reset cycle.
  - At most one of pc_write and branch is high in any cycle.
  - Zero-wait memory gives these latencies: R-type 4 cycles, load 5, store 4, branch 3.

Optional Feature:
- Macro: ILLEGAL_INSTR_EN.
- Enabled:
  - Unknown opcode in DECODE goes to TRAP.
  - TRAP drives o_illegal_instr=1 (extra 1-bit output) and no strobes.
  - Only reset leaves TRAP.
- Disabled:
  - Port is absent and unknown opcodes return to FETCH as a NOP.
  - State 14 is unreachable.

Test Plan:
- Reset mid-MEM_READ with i_mem_ready=0 -> o_state=0 immediately, all strobes 0. After release, o_mem_req=1 and adr_src=0.
- R-type add (i_op=0110011), i_mem_ready tied 1 -> states 0,1,6,8,0. alu_op=10 in EXEC_R; reg_write=1 only in ALU_WB.
- Load (0000011), i_mem_ready low for 3 cycles in MEM_READ -> stays in state 3 for 4 cycles, then MEM_WB with result_src=01, reg_write=1.
- Store (0100011) -> MEM_WRITE asserts mem_write=1 and adr_src=1 until ready, then FETCH. reg_write never 1.
- JALR (1100111) -> states 0,1,11,10,8,0. pc_write=1 in JAL only; alu_op=00 throughout.
- Opcode 1111111 -> with ILLEGAL_INSTR_EN, state 14 and o_illegal_instr=1 held for 10 cycles. Without it, returns to state 0 with no reg_write or mem_write.
